// File: rtl/crop_word_packer.sv
// Packs PIXELS_PER_WORD consecutive pixels of one cropped frame into a wide
// AXI-Stream word with tkeep/tlast, under ap_start/ap_done/ap_ready control.
`timescale 1ns/1ps
module crop_word_packer #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  parameter int PIXELS_PER_WORD = 4
) (
  input  logic                                       clk,
  input  logic                                       srst,
  input  logic                                       ap_start,
  output logic                                       ap_ready,
  output logic                                       ap_idle,
  output logic                                       ap_done,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]                 s_axis_tdata,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic [PIXELS_PER_WORD*PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic [PIXELS_PER_WORD-1:0]                 m_axis_tkeep,
  output logic                                       m_axis_tlast
);

  localparam int TOTAL  = OUT_ROWS * OUT_COLS;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int LANE_W = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(PIXELS_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TOTAL);

  typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    pix_cnt;
  logic [LANE_W-1:0]   lane;
  logic [CNT_W-1:0]    pix_cnt_nxt;

  assign pix_cnt_nxt = pix_cnt + CNT_W'(1);
  assign ap_ready    = (state == IDLE);
  assign ap_idle     = (state == IDLE);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      lane          <= '0;
      ap_done       <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ap_done <= 1'b0;
          if (ap_start) begin
            state         <= FILL;
            pix_cnt       <= '0;
            lane          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b1;
          end
        end
        FILL: begin
          if (s_axis_tvalid && s_axis_tready) begin
            for (int k = 0; k < PIXELS_PER_WORD; k++) begin
              if (lane == LANE_W'(k)) begin
                m_axis_tdata[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] <= s_axis_tdata;
                m_axis_tkeep[k] <= 1'b1;
              end
            end
            lane         <= lane + LANE_W'(1);
            pix_cnt      <= pix_cnt_nxt;
            m_axis_tlast <= (pix_cnt_nxt == CNT_LAST);
            // A word closes on its last lane or on the frame's final pixel.
            if (lane == LANE_MAX || pix_cnt_nxt == CNT_LAST) begin
              state         <= SEND;
              s_axis_tready <= 1'b0;
              m_axis_tvalid <= 1'b1;
            end
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            if (m_axis_tlast) begin
              state        <= DONE;
              ap_done      <= 1'b1;
              m_axis_tlast <= 1'b0;
            end else begin
              state         <= FILL;
              lane          <= '0;
              m_axis_tdata  <= '0;
              m_axis_tkeep  <= '0;
              s_axis_tready <= 1'b1;
            end
          end
        end
        DONE: begin
          ap_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
